mux_arb_n: RTL and testbench
============================

# mux_arb_n

Parametrised N-input, WIDTH-bit registered selector with valid/ready handshaking on every input and on the output. It replaces fixed combinational 2:1/3:1 selectors where sources produce results on different cycles, e.g. writeback source selection (ALU / memory / PC+4 / extra units) ahead of the register file. Three selection modes are fixed at elaboration: direct select, fixed priority, and round-robin. One output register gives a one-cycle latency and full backpressure.

## Interface
- WIDTH, 32, data width of every input and of the output
- NUM_IN, 3, number of input channels, legal range 2..16
- MODE, 0, 0 = direct (sel port), 1 = fixed priority (lowest index wins), 2 = round-robin
- SELW, $clog2(NUM_IN), select/source-index width, derived, not overridden
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- in_data  in  NUM_IN*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  in  NUM_IN  channel i offers a word
- in_ready  out  NUM_IN  channel i word accepted this cycle (one-hot or zero)
- sel  in  SELW  channel choice, used only when MODE = 0
- out_data  out  WIDTH  registered selected word
- out_valid  out  1  out_data holds an unconsumed word
- out_ready  in  1  consumer accepts out_data this cycle
- out_src  out  SELW  index of the channel that supplied out_data

## Operation
- load_en = !out_valid || out_ready; the output register loads only when load_en = 1.
- Grant g is computed combinationally each cycle; in_ready[g] = load_en && in_valid[g]; all other in_ready bits are 0.
- Transfer on channel i happens when in_valid[i] && in_ready[i]; on that edge out_data <= channel i word, out_src <= i, out_valid <= 1.
- load_en = 1 with no grant: out_valid <= 0; out_data and out_src hold.
- MODE 0: candidate = sel if sel < NUM_IN, else NUM_IN-1 (out-of-range select falls to the last channel). If in_valid[candidate] = 0 there is no grant; no other channel is considered.
- MODE 1: the lowest-index channel with in_valid = 1 is granted.
- MODE 2: the search starts at ptr+1 and wraps modulo NUM_IN. The first valid channel found is granted. ptr <= g only on a transfer; ptr holds otherwise.
- Sources must hold in_valid and in_data stable until accepted. The block does not check this.
- While out_valid && !out_ready: out_data, out_src and out_valid are held stable, and in_ready = 0. A change in sel or in_valid has no effect on the held word.

## Timing
- Reset values (asynchronous, applied immediately): out_valid = 0, out_data = 0, out_src = 0, ptr = NUM_IN-1, so channel 0 is searched first after reset.
- Reset asserted mid-operation discards the held word. in_ready is 0 while rst = 0.
- Latency: an input accepted at edge k is visible on out_data after edge k, and is consumable in cycle k+1.
- Throughput: one word per cycle while out_ready = 1 and at least one eligible channel is valid.
- Simultaneous drain and load in the same cycle (out_valid && out_ready && grant) is legal; out_valid stays 1 with no bubble.
- in_ready depends combinationally on out_ready, in_valid and sel. No output depends combinationally on in_data.

## Structure
- Shared include/package mux_arb_defs: MODE_DIRECT = 0, MODE_PRIO = 1, MODE_RR = 2, and the NUM_IN range limits. The top-level and the bench both use it.
- Sub-module rr_grant_n (NUM_IN, SELW): inputs req, ptr, mode, sel; outputs one-hot grant, gnt_idx and gnt_any. Purely combinational.
- The top level holds the output register, ptr, the load_en logic and a generate-time assertion on the legality of NUM_IN and MODE.

## Test plan
- MODE 0, NUM_IN = 3, WIDTH = 32; sel = 0,1,2,3 over four cycles with all in_valid = 1 and inputs 0xA, 0xB, 0xC -> out_data = 0xA, 0xB, 0xC, 0xC one cycle later each, with out_src = 0,1,2,2.
- MODE 1, NUM_IN = 4; in_valid = 4'b1010 held, out_ready = 1 -> channel 1 granted every cycle; in_ready = 4'b0010 and out_src = 1.
- MODE 2, NUM_IN = 4; all valid, out_ready = 1 for 6 cycles after reset -> out_src = 0,1,2,3,0,1.
- Backpressure: word 0x55 held with out_ready = 0 for 3 cycles while sel/in_valid toggle -> out_data stays 0x55, in_ready = 0. Release out_ready -> next word loads the same cycle, with no bubble.
- Idle drain: a single transfer of 0x77, then all in_valid = 0 with out_ready = 1 -> out_valid falls after one cycle and out_data stays 0x77.
- Async reset: rst pulled low mid-cycle while out_valid = 1 -> out_valid, out_data and out_src go to 0 before the next edge. MODE 2 then restarts the search at channel 0.

Source files
------------

// File: rtl/mux_arb_n_pkg.sv
// Shared definitions for the mux_arb_n registered selector: the selection-mode
// encodings and the legal channel-count range.
package mux_arb_defs;

  localparam logic [1:0] MODE_DIRECT = 2'd0;
  localparam logic [1:0] MODE_PRIO   = 2'd1;
  localparam logic [1:0] MODE_RR     = 2'd2;

  localparam int NUM_IN_MIN = 2;
  localparam int NUM_IN_MAX = 16;

endpackage

// File: rtl/mux_arb_n_rr_grant_n.sv
// Combinational grant selection for mux_arb_n: direct select, fixed priority
// (lowest index wins) or round-robin starting one past ptr.
module rr_grant_n
  import mux_arb_defs::*;
#(
  parameter int NUM_IN = 3,
  parameter int SELW   = 2
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [SELW-1:0]   ptr,
  input  logic [1:0]        mode,
  input  logic [SELW-1:0]   sel,
  output logic [NUM_IN-1:0] grant,
  output logic [SELW-1:0]   gnt_idx,
  output logic              gnt_any
);

  logic [SELW-1:0] cand;
  logic [SELW-1:0] rr_idx;

  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = '0;
    rr_idx  = '0;
    case (mode)
      MODE_DIRECT: begin
        // An out-of-range select falls back to the last channel only.
        cand    = (int'(sel) < NUM_IN) ? sel : SELW'(NUM_IN - 1);
        gnt_idx = cand;
        gnt_any = req[cand];
      end
      MODE_PRIO: begin
        for (int i = NUM_IN - 1; i >= 0; i--) begin
          if (req[i]) begin
            gnt_idx = SELW'(i);
            gnt_any = 1'b1;
          end
        end
      end
      MODE_RR: begin
        // Walk offsets downward so the nearest valid channel after ptr wins.
        for (int k = NUM_IN; k >= 1; k--) begin
          rr_idx = SELW'((int'(ptr) + k) % NUM_IN);
          if (req[rr_idx]) begin
            gnt_idx = rr_idx;
            gnt_any = 1'b1;
          end
        end
      end
      default: ;
    endcase
    if (gnt_any) grant[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/mux_arb_n.sv
// N-input registered selector with valid/ready on every channel and on the
// output; one output register gives one-cycle latency and full backpressure.
module mux_arb_n
  import mux_arb_defs::*;
#(
  parameter  int WIDTH  = 32,
  parameter  int NUM_IN = 3,
  parameter  int MODE   = 0,
  localparam int SELW   = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic [SELW-1:0]         sel,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SELW-1:0]         out_src
);

  if (NUM_IN < NUM_IN_MIN || NUM_IN > NUM_IN_MAX || MODE < 0 || MODE > 2) begin : g_param_check
    $error("mux_arb_n: illegal NUM_IN or MODE");
  end

  localparam logic [1:0] MODE_SEL = 2'(MODE);

  logic [NUM_IN-1:0] grant;
  logic [SELW-1:0]   gnt_idx;
  logic              gnt_any;
  logic              load_en;

  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  out_data_q,  out_data_d;
  logic [SELW-1:0]   out_src_q,   out_src_d;
  logic [SELW-1:0]   ptr_q,       ptr_d;

  rr_grant_n #(
    .NUM_IN (NUM_IN),
    .SELW   (SELW)
  ) u_grant (
    .req     (in_valid),
    .ptr     (ptr_q),
    .mode    (MODE_SEL),
    .sel     (sel),
    .grant   (grant),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  assign load_en  = !out_valid_q || out_ready;
  // Gated by rst so no channel sees an accept while the block is held in reset.
  assign in_ready = (load_en && rst) ? grant : '0;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    ptr_d       = ptr_q;
    if (load_en) begin
      out_valid_d = gnt_any;
      if (gnt_any) begin
        for (int i = 0; i < NUM_IN; i++) begin
          if (grant[i]) out_data_d = in_data[i*WIDTH +: WIDTH];
        end
        out_src_d = gnt_idx;
        ptr_d     = gnt_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      ptr_q       <= SELW'(NUM_IN - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

endmodule

// File: tb/tb_mux_arb_n.sv
// Directed bench for mux_arb_n: one instance per selection mode, table-driven
// vectors plus hand-written backpressure, drain and async-reset sequences.
module tb_mux_arb_n;
  import mux_arb_defs::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  // Direct-select instance, three channels
  logic [95:0]  d0_in_data;
  logic [2:0]   d0_in_valid, d0_in_ready;
  logic [1:0]   d0_sel, d0_out_src;
  logic [31:0]  d0_out_data;
  logic         d0_out_valid, d0_out_ready;

  // Fixed-priority instance, four channels
  logic [127:0] d1_in_data;
  logic [3:0]   d1_in_valid, d1_in_ready;
  logic [1:0]   d1_sel, d1_out_src;
  logic [31:0]  d1_out_data;
  logic         d1_out_valid, d1_out_ready;

  // Round-robin instance, four channels
  logic [127:0] d2_in_data;
  logic [3:0]   d2_in_valid, d2_in_ready;
  logic [1:0]   d2_sel, d2_out_src;
  logic [31:0]  d2_out_data;
  logic         d2_out_valid, d2_out_ready;

  mux_arb_n #(.WIDTH(32), .NUM_IN(3), .MODE(0)) dut0 (
    .clk(clk), .rst(rst), .in_data(d0_in_data), .in_valid(d0_in_valid),
    .in_ready(d0_in_ready), .sel(d0_sel), .out_data(d0_out_data),
    .out_valid(d0_out_valid), .out_ready(d0_out_ready), .out_src(d0_out_src)
  );

  mux_arb_n #(.WIDTH(32), .NUM_IN(4), .MODE(1)) dut1 (
    .clk(clk), .rst(rst), .in_data(d1_in_data), .in_valid(d1_in_valid),
    .in_ready(d1_in_ready), .sel(d1_sel), .out_data(d1_out_data),
    .out_valid(d1_out_valid), .out_ready(d1_out_ready), .out_src(d1_out_src)
  );

  mux_arb_n #(.WIDTH(32), .NUM_IN(4), .MODE(2)) dut2 (
    .clk(clk), .rst(rst), .in_data(d2_in_data), .in_valid(d2_in_valid),
    .in_ready(d2_in_ready), .sel(d2_sel), .out_data(d2_out_data),
    .out_valid(d2_out_valid), .out_ready(d2_out_ready), .out_src(d2_out_src)
  );

  typedef struct {
    logic [1:0]  sel;
    logic [2:0]  exp_rdy;
    logic [31:0] exp_data;
    logic [1:0]  exp_src;
  } vec0_t;

  typedef struct {
    logic [3:0]  exp_rdy;
    logic [31:0] exp_data;
    logic [1:0]  exp_src;
  } vec2_t;

  vec0_t vecs0[4];
  vec2_t vecs2[6];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not reach its end within the time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge, away from the sampling point.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;

    vecs0[0] = '{2'd0, 3'b001, 32'hA, 2'd0};
    vecs0[1] = '{2'd1, 3'b010, 32'hB, 2'd1};
    vecs0[2] = '{2'd2, 3'b100, 32'hC, 2'd2};
    vecs0[3] = '{2'd3, 3'b100, 32'hC, 2'd2};

    vecs2[0] = '{4'b0001, 32'h200, 2'd0};
    vecs2[1] = '{4'b0010, 32'h201, 2'd1};
    vecs2[2] = '{4'b0100, 32'h202, 2'd2};
    vecs2[3] = '{4'b1000, 32'h203, 2'd3};
    vecs2[4] = '{4'b0001, 32'h200, 2'd0};
    vecs2[5] = '{4'b0010, 32'h201, 2'd1};

    d0_in_data = {32'hC, 32'hB, 32'hA};
    d0_in_valid = 3'b111; d0_sel = 2'd0; d0_out_ready = 1'b1;
    d1_in_data = {32'h103, 32'h102, 32'h101, 32'h100};
    d1_in_valid = 4'b0000; d1_sel = 2'd0; d1_out_ready = 1'b1;
    d2_in_data = {32'h203, 32'h202, 32'h201, 32'h200};
    d2_in_valid = 4'b0000; d2_sel = 2'd0; d2_out_ready = 1'b1;

    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    checkOutput("reset_out_valid", 64'(d0_out_valid), 64'(1'b0));
    checkOutput("reset_out_data", 64'(d0_out_data), 64'(32'h0));
    checkOutput("reset_out_src", 64'(d0_out_src), 64'(2'd0));
    checkOutput("reset_in_ready", 64'(d0_in_ready), 64'(3'b000));
    applyStimulus();
    rst = 1'b1;

    // Direct select, including the out-of-range select
    for (int i = 0; i < 4; i++) begin
      d0_sel = vecs0[i].sel;
      #1;
      checkOutput($sformatf("direct_in_ready[%0d]", i), 64'(d0_in_ready), 64'(vecs0[i].exp_rdy));
      applyStimulus();
      checkOutput($sformatf("direct_out_data[%0d]", i), 64'(d0_out_data), 64'(vecs0[i].exp_data));
      checkOutput($sformatf("direct_out_src[%0d]", i), 64'(d0_out_src), 64'(vecs0[i].exp_src));
      checkOutput($sformatf("direct_out_valid[%0d]", i), 64'(d0_out_valid), 64'(1'b1));
    end

    // Fixed priority with channels 1 and 3 valid
    d1_in_valid = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput($sformatf("prio_in_ready[%0d]", i), 64'(d1_in_ready), 64'(4'b0010));
      applyStimulus();
      checkOutput($sformatf("prio_out_src[%0d]", i), 64'(d1_out_src), 64'(2'd1));
      checkOutput($sformatf("prio_out_data[%0d]", i), 64'(d1_out_data), 64'(32'h101));
    end
    d1_in_valid = 4'b0000;

    // Round robin from reset with every channel valid
    d2_in_valid = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      #1;
      checkOutput($sformatf("rr_in_ready[%0d]", i), 64'(d2_in_ready), 64'(vecs2[i].exp_rdy));
      applyStimulus();
      checkOutput($sformatf("rr_out_src[%0d]", i), 64'(d2_out_src), 64'(vecs2[i].exp_src));
      checkOutput($sformatf("rr_out_data[%0d]", i), 64'(d2_out_data), 64'(vecs2[i].exp_data));
    end
    d2_in_valid = 4'b0000;

    // Backpressure: hold 0x55 while select and valids toggle
    d0_in_valid = 3'b000;
    applyStimulus();
    checkOutput("bp_idle_valid", 64'(d0_out_valid), 64'(1'b0));
    d0_in_data = {32'h77, 32'h66, 32'h55};
    d0_sel = 2'd0; d0_in_valid = 3'b001;
    applyStimulus();
    checkOutput("bp_load_data", 64'(d0_out_data), 64'(32'h55));
    d0_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      d0_sel = 2'(i + 1);
      d0_in_valid = (i == 1) ? 3'b010 : 3'b111;
      #1;
      checkOutput($sformatf("bp_in_ready[%0d]", i), 64'(d0_in_ready), 64'(3'b000));
      applyStimulus();
      checkOutput($sformatf("bp_hold_data[%0d]", i), 64'(d0_out_data), 64'(32'h55));
      checkOutput($sformatf("bp_hold_src[%0d]", i), 64'(d0_out_src), 64'(2'd0));
      checkOutput($sformatf("bp_hold_valid[%0d]", i), 64'(d0_out_valid), 64'(1'b1));
    end
    d0_out_ready = 1'b1; d0_sel = 2'd1; d0_in_valid = 3'b111;
    #1;
    checkOutput("bp_release_in_ready", 64'(d0_in_ready), 64'(3'b010));
    applyStimulus();
    checkOutput("bp_release_data", 64'(d0_out_data), 64'(32'h66));
    checkOutput("bp_release_src", 64'(d0_out_src), 64'(2'd1));
    checkOutput("bp_release_valid", 64'(d0_out_valid), 64'(1'b1));

    // Idle drain: single 0x77 transfer then nothing valid
    d0_sel = 2'd2; d0_in_valid = 3'b100;
    applyStimulus();
    checkOutput("drain_load_data", 64'(d0_out_data), 64'(32'h77));
    d0_in_valid = 3'b000;
    applyStimulus();
    checkOutput("drain_valid_low", 64'(d0_out_valid), 64'(1'b0));
    checkOutput("drain_data_held", 64'(d0_out_data), 64'(32'h77));
    checkOutput("drain_src_held", 64'(d0_out_src), 64'(2'd2));

    // Async reset mid-cycle on the round-robin instance (ptr was left at 1)
    d2_in_valid = 4'b1111;
    applyStimulus();
    checkOutput("arst_pre_src", 64'(d2_out_src), 64'(2'd2));
    checkOutput("arst_pre_valid", 64'(d2_out_valid), 64'(1'b1));
    #2 rst = 1'b0;
    #1;
    checkOutput("arst_out_valid", 64'(d2_out_valid), 64'(1'b0));
    checkOutput("arst_out_data", 64'(d2_out_data), 64'(32'h0));
    checkOutput("arst_out_src", 64'(d2_out_src), 64'(2'd0));
    checkOutput("arst_in_ready", 64'(d2_in_ready), 64'(4'b0000));
    #1 rst = 1'b1;
    applyStimulus();
    checkOutput("arst_restart_src0", 64'(d2_out_src), 64'(2'd0));
    checkOutput("arst_restart_data0", 64'(d2_out_data), 64'(32'h200));
    applyStimulus();
    checkOutput("arst_restart_src1", 64'(d2_out_src), 64'(2'd1));
    d2_in_valid = 4'b0000;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
